dma_bus_arbiter: RTL and testbench

- CPU-side responder to the DMA controller's bus-request handshake.
- Samples `BR`, drains any in-flight CPU memory access, then returns `BG`. Stalls the CPU and steers the shared memory bus to the DMA engine while granted.
- Latches the DMA-end pulse into a level interrupt for the CPU.
- Sits between the CPU datapath, the DMA controller and the memory-bus mux.

---
 rtl/dma_bus_arbiter.sv | 114 +++++++++++
 tb/tb_dma_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arbiter.sv
// CPU-side bus arbiter answering the DMA controller's BR/BG handshake.
// Optional watchdog on grant length: define BUS_WATCHDOG_EN.
module dma_bus_arbiter #(
    parameter int MAX_GRANT = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 BR,
    input  logic                 cpu_mem_req,
    input  logic                 cpu_mem_done,
    input  logic                 dma_end_interrupt,
    input  logic                 irq_ack,
    output logic                 BG,
    output logic                 cpu_stall,
    output logic                 bus_owner,
    output logic                 irq_dma,
    output logic [CNT_WIDTH-1:0] grant_count,
    output logic                 bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GRANT,
        RELEASE
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   wd_timeout;
    logic   wd_block;

`ifdef BUS_WATCHDOG_EN
    localparam int WD_W = $clog2(MAX_GRANT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // wd_cnt holds GRANT cycles already completed, so the limit hits
    // on the MAX_GRANT-th cycle in GRANT
    assign wd_timeout = (state_q == GRANT) && BR &&
                        (wd_cnt == WD_W'(MAX_GRANT - 1));
    assign wd_block   = err_q;
    assign bus_error  = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != GRANT)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_timeout = 1'b0;
    assign wd_block   = 1'b0;
    assign bus_error  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (BR && !wd_block)
                    state_d = cpu_mem_req ? DRAIN : GRANT;
            end
            DRAIN: begin
                if (!BR)
                    state_d = IDLE;
                else if (cpu_mem_done)
                    state_d = GRANT;
            end
            GRANT: begin
                if (!BR || wd_timeout)
                    state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BG        = (state_q == GRANT);
    assign bus_owner = (state_q == GRANT) || (state_q == RELEASE);
    assign cpu_stall = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_count <= '0;
            irq_dma     <= 1'b0;
        end else begin
            if (state_q == RELEASE)
                grant_count <= grant_count + CNT_WIDTH'(1);
            // a new end pulse outranks a simultaneous acknowledge
            if (dma_end_interrupt)
                irq_dma <= 1'b1;
            else if (irq_ack)
                irq_dma <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: behavioural model plus
// directed scenarios with literal expectations.
module tb_dma_bus_arbiter;

    localparam int MAXG = 8;
    localparam int CW   = 3;
`ifdef BUS_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          BR;
    logic          cpu_mem_req;
    logic          cpu_mem_done;
    logic          dma_end_interrupt;
    logic          irq_ack;
    logic          BG;
    logic          cpu_stall;
    logic          bus_owner;
    logic          irq_dma;
    logic [CW-1:0] grant_count;
    logic          bus_error;

    int tests = 0;
    int fails = 0;

    dma_bus_arbiter #(
        .MAX_GRANT(MAXG),
        .CNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .BR               (BR),
        .cpu_mem_req      (cpu_mem_req),
        .cpu_mem_done     (cpu_mem_done),
        .dma_end_interrupt(dma_end_interrupt),
        .irq_ack          (irq_ack),
        .BG               (BG),
        .cpu_stall        (cpu_stall),
        .bus_owner        (bus_owner),
        .irq_dma          (irq_dma),
        .grant_count      (grant_count),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    // model: the bus is "held by DMA" (m_own), "granted" (m_bg),
    // "CPU frozen" (m_stall); a turnaround is held-but-not-granted
    logic m_bg, m_own, m_stall, m_irq, m_err;
    int   m_cnt;
    int   m_gcyc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_bg <= 0; m_own <= 0; m_stall <= 0;
            m_irq <= 0; m_err <= 0; m_cnt <= 0; m_gcyc <= 0;
        end else begin
            if (dma_end_interrupt) m_irq <= 1;
            else if (irq_ack) m_irq <= 0;
            if (m_own && !m_bg) begin
                m_own <= 0; m_stall <= 0;
                m_cnt <= (m_cnt + 1) % (1 << CW);
            end else if (m_bg) begin
                if (!BR) m_bg <= 0;
                else if (WD && m_gcyc == MAXG) begin
                    m_bg <= 0; m_err <= 1;
                end else m_gcyc <= m_gcyc + 1;
            end else if (m_stall) begin
                if (!BR) m_stall <= 0;
                else if (cpu_mem_done) begin
                    m_bg <= 1; m_own <= 1; m_gcyc <= 1;
                end
            end else if (BR && !m_err) begin
                m_stall <= 1;
                if (!cpu_mem_req) begin
                    m_bg <= 1; m_own <= 1; m_gcyc <= 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    int bgc, ownc, mism;

    initial begin
        reset_n = 0; BR = 0; cpu_mem_req = 0; cpu_mem_done = 0;
        dma_end_interrupt = 0; irq_ack = 0;

        fork
            forever begin
                @(negedge clk);
                if (reset_n) begin
                    chk("BG", int'(BG), int'(m_bg));
                    chk("bus_owner", int'(bus_owner), int'(m_own));
                    chk("cpu_stall", int'(cpu_stall), int'(m_stall));
                    chk("irq_dma", int'(irq_dma), int'(m_irq));
                    chk("grant_count", int'(grant_count), m_cnt);
                    chk("bus_error", int'(bus_error), int'(m_err));
                end
            end
        join_none

        #1;
        chk("rst_BG", int'(BG), 0);
        chk("rst_stall", int'(cpu_stall), 0);
        chk("rst_owner", int'(bus_owner), 0);
        chk("rst_irq", int'(irq_dma), 0);
        chk("rst_cnt", int'(grant_count), 0);
        chk("rst_err", int'(bus_error), 0);
        nclk(2);
        reset_n = 1;
        nclk(1);

        // uncontended grant, with a stray done pulse while granted
        bgc = 0; ownc = 0; mism = 0;
        BR = 1;
        for (int i = 0; i < 8; i++) begin
            nclk(1);
            bgc += int'(BG);
            ownc += int'(bus_owner);
            if (cpu_stall != bus_owner) mism++;
            cpu_mem_done = (i == 2);
            if (i == 4) BR = 0;
        end
        chk("unc_bg_cycles", bgc, 5);
        chk("unc_own_cycles", ownc, 6);
        chk("unc_stall_eq_own", mism, 0);
        chk("unc_count", int'(grant_count), 1);

        // drain: done pulsed three cycles after the request
        BR = 1; cpu_mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            nclk(1);
            chk("drain_bg", int'(BG), 0);
            chk("drain_stall", int'(cpu_stall), 1);
        end
        cpu_mem_done = 1;
        nclk(1);
        chk("drain_grant", int'(BG), 1);
        cpu_mem_done = 0; cpu_mem_req = 0; BR = 0;
        nclk(3);
        chk("drain_count", int'(grant_count), 2);

        // withdrawn request from DRAIN
        BR = 1; cpu_mem_req = 1; bgc = 0;
        nclk(2);
        chk("wd_in_drain", int'(cpu_stall), 1);
        BR = 0;
        nclk(1);
        chk("wd_idle_stall", int'(cpu_stall), 0);
        nclk(1);
        chk("wd_count", int'(grant_count), 2);
        cpu_mem_req = 0;

        // interrupt set / set-vs-ack / lone ack
        dma_end_interrupt = 1;
        nclk(1);
        dma_end_interrupt = 0;
        nclk(1);
        chk("irq_set", int'(irq_dma), 1);
        dma_end_interrupt = 1; irq_ack = 1;
        nclk(1);
        dma_end_interrupt = 0; irq_ack = 1;
        chk("irq_set_wins", int'(irq_dma), 1);
        nclk(1);
        irq_ack = 0;
        chk("irq_ack_clr", int'(irq_dma), 0);

        // BR falls with end pulse; BR re-raised during RELEASE
        BR = 1;
        nclk(1);
        chk("rr_grant", int'(BG), 1);
        BR = 0; dma_end_interrupt = 1;
        nclk(1);
        chk("rr_release_bg", int'(BG), 0);
        chk("rr_release_own", int'(bus_owner), 1);
        chk("rr_irq", int'(irq_dma), 1);
        BR = 1; dma_end_interrupt = 0;
        nclk(1);
        chk("rr_idle_own", int'(bus_owner), 0);
        chk("rr_idle_bg", int'(BG), 0);
        nclk(1);
        chk("rr_regrant", int'(BG), 1);
        BR = 0; irq_ack = 1;
        nclk(1);
        irq_ack = 0;
        nclk(2);
        chk("rr_count", int'(grant_count), 4);

        // asynchronous reset while granted
        BR = 1;
        nclk(2);
        #2;
        reset_n = 0;
        #1;
        chk("arst_BG", int'(BG), 0);
        chk("arst_owner", int'(bus_owner), 0);
        chk("arst_stall", int'(cpu_stall), 0);
        chk("arst_cnt", int'(grant_count), 0);
        BR = 0;
        nclk(1);
        reset_n = 1;
        nclk(1);

        // nine grants wrap a 3-bit counter to 1
        for (int g = 0; g < 9; g++) begin
            BR = 1;
            nclk(1);
            BR = 0;
            nclk(2);
        end
        chk("wrap_count", int'(grant_count), 1);

`ifdef BUS_WATCHDOG_EN
        bgc = 0;
        BR = 1;
        for (int i = 0; i < 12; i++) begin
            nclk(1);
            bgc += int'(BG);
        end
        chk("wdog_bg_cycles", bgc, MAXG);
        chk("wdog_err", int'(bus_error), 1);
        chk("wdog_count", int'(grant_count), 2);
        BR = 0;
        nclk(2);
        BR = 1; bgc = 0;
        for (int i = 0; i < 4; i++) begin
            nclk(1);
            bgc += int'(BG) + int'(cpu_stall);
        end
        chk("wdog_blocked", bgc, 0);
        BR = 0;
        nclk(1);
        reset_n = 0;
        #1;
        chk("wdog_rst_err", int'(bus_error), 0);
        nclk(1);
        reset_n = 1;
        BR = 1;
        nclk(1);
        chk("wdog_regrant", int'(BG), 1);
        BR = 0;
        nclk(3);
`else
        chk("no_wdog_err", int'(bus_error), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
